// File: rtl/rfblackwidow_fill_arb_pkg.sv
// Shared definitions for the BlackWidow L1 line-fill arbiter.
// Line sizes of both L1 caches, the memory beat width, the beat counts
// derived from them, and the fill sequencer state type.
package rfblackwidow_fill_arb_pkg;

    localparam int L1I_LINE_SIZE = 672;
    localparam int L1D_LINE_SIZE = 512;
    localparam int BUS_WID_C     = 128;

    // Round up: the I-line is padded to a whole number of beats.
    localparam int IBEATS_C = (L1I_LINE_SIZE + BUS_WID_C - 1) / BUS_WID_C;
    localparam int DBEATS_C = (L1D_LINE_SIZE + BUS_WID_C - 1) / BUS_WID_C;

    localparam int BEAT_W = 3;

    localparam logic GNT_I = 1'b1;
    localparam logic GNT_D = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IFILL = 2'd1,
        DFILL = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/rfblackwidow_fill_arb_line_asm.sv
// Beat-indexed line assembly register.
// Ports:
//   clk, rst  clock and synchronous active-high reset (clears the line)
//   we        write enable for one beat
//   slot      beat index; slot 0 lands in the LSBs
//   din       one bus beat
//   line      assembled line
module rfblackwidow_fill_arb_line_asm
    import rfblackwidow_fill_arb_pkg::*;
#(
    parameter int LINE_W = 512,
    parameter int BUS_W  = BUS_WID_C,
    parameter int SLOT_W = BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [SLOT_W-1:0] slot,
    input  logic [BUS_W-1:0]  din,
    output logic [LINE_W-1:0] line
);

    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
        end else if (we) begin
            line[int'(slot)*BUS_W +: BUS_W] <= din;
        end
    end

endmodule

// File: rtl/rfblackwidow_fill_arb.sv
// Cache-line fill arbiter/sequencer for the BlackWidow L1 I and D caches.
// Grants one miss at a time (round-robin on ties), bursts the line in over
// the Wishbone-style memory port and returns it with a one-cycle ack.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   imiss_req/imiss_adr          I-cache miss request and address
//   imiss_ack/iline_o            I-line return pulse and 672-bit line
//   dmiss_req/dmiss_adr          D-cache miss request and address
//   dmiss_ack/dline_o            D-line return pulse and 512-bit line
//   fill_err                     qualifies the ack: fill was aborted
//   cyc_o/stb_o/adr_o            memory bus cycle, strobe, beat address
//   ack_i/err_i/dat_i            memory bus beat ack, error, beat data
// Optional build macro RFBW_FILL_TIMEOUT_EN: aborts a fill after TMO
// consecutive cycles without a beat ack.
module rfblackwidow_fill_arb
    import rfblackwidow_fill_arb_pkg::*;
#(
    parameter int BUS_WID = BUS_WID_C,
    parameter int IBEATS  = IBEATS_C,
    parameter int DBEATS  = DBEATS_C,
    parameter int TMO     = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     imiss_req,
    input  logic [39:0]              imiss_adr,
    output logic                     imiss_ack,
    output logic [L1I_LINE_SIZE-1:0] iline_o,
    input  logic                     dmiss_req,
    input  logic [39:0]              dmiss_adr,
    output logic                     dmiss_ack,
    output logic [L1D_LINE_SIZE-1:0] dline_o,
    output logic                     fill_err,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic [39:0]              adr_o,
    input  logic                     ack_i,
    input  logic                     err_i,
    input  logic [BUS_WID-1:0]       dat_i
);

    fill_state_t                state, state_n;
    logic [BEAT_W-1:0]          beat, beat_nxt;
    logic [39:0]                base, ibase, dbase;
    logic                       last_g, cur_g;
    logic                       grant_i, grant_d, beat_ack, abort, final_beat;
    logic                       tmo_hit;
    logic [IBEATS*BUS_WID-1:0]  iline_full;

    assign ibase    = {imiss_adr[39:7], 7'd0};
    assign dbase    = {dmiss_adr[39:6], 6'd0};
    assign beat_nxt = beat + BEAT_W'(1);

    always_comb begin
        state_n    = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        beat_ack   = 1'b0;
        abort      = 1'b0;
        final_beat = 1'b0;
        unique case (state)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (imiss_req && (!dmiss_req || last_g == GNT_D)) begin
                    grant_i = 1'b1;
                    state_n = IFILL;
                end else if (dmiss_req) begin
                    grant_d = 1'b1;
                    state_n = DFILL;
                end
            end
            IFILL, DFILL: begin
                // Error beats a simultaneous ack; an ack without strobe is ignored.
                abort      = stb_o && (err_i || tmo_hit);
                beat_ack   = stb_o && ack_i && !abort;
                final_beat = (state == IFILL) ? (beat == BEAT_W'(IBEATS - 1))
                                              : (beat == BEAT_W'(DBEATS - 1));
                if (abort || (beat_ack && final_beat)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            beat      <= '0;
            last_g    <= GNT_D;
            cur_g     <= GNT_D;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            adr_o     <= '0;
            imiss_ack <= 1'b0;
            dmiss_ack <= 1'b0;
            fill_err  <= 1'b0;
        end else begin
            state     <= state_n;
            imiss_ack <= 1'b0;
            dmiss_ack <= 1'b0;
            fill_err  <= 1'b0;
            if (grant_i || grant_d) begin
                base  <= grant_i ? ibase : dbase;
                adr_o <= grant_i ? ibase : dbase;
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                beat  <= '0;
                cur_g <= grant_i;
            end
            if (beat_ack) begin
                beat <= beat_nxt;
                // After the last beat the bus drops, so the address just holds.
                if (!final_beat) begin
                    adr_o <= base + 40'(beat_nxt) * 40'(BUS_WID / 8);
                end
            end
            if (state_n == DONE && state != DONE) begin
                cyc_o     <= 1'b0;
                stb_o     <= 1'b0;
                fill_err  <= abort;
                imiss_ack <= cur_g;
                dmiss_ack <= !cur_g;
            end
            if (state == DONE) begin
                last_g <= cur_g;
            end
        end
    end

`ifdef RFBW_FILL_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || grant_i || grant_d) begin
            tmo_cnt <= '0;
        end else if (state == IFILL || state == DFILL) begin
            tmo_cnt <= ack_i ? 8'd0 : tmo_cnt + 8'd1;
        end
    end

    assign tmo_hit = (tmo_cnt == 8'(TMO));
`else
    logic [7:0] tmo_unused;

    assign tmo_unused = 8'(TMO);
    assign tmo_hit    = 1'b0;
`endif

    rfblackwidow_fill_arb_line_asm #(
        .LINE_W (IBEATS * BUS_WID),
        .BUS_W  (BUS_WID),
        .SLOT_W (BEAT_W)
    ) u_iline (
        .clk  (clk_i),
        .rst  (rst_i),
        .we   (beat_ack && state == IFILL),
        .slot (beat),
        .din  (dat_i),
        .line (iline_full)
    );

    rfblackwidow_fill_arb_line_asm #(
        .LINE_W (L1D_LINE_SIZE),
        .BUS_W  (BUS_WID),
        .SLOT_W (BEAT_W)
    ) u_dline (
        .clk  (clk_i),
        .rst  (rst_i),
        .we   (beat_ack && state == DFILL),
        .slot (beat),
        .din  (dat_i),
        .line (dline_o)
    );

    // Only the low 672 bits of the padded I-line are real instruction bits.
    assign iline_o = iline_full[L1I_LINE_SIZE-1:0];

    logic unused_bits;
    assign unused_bits = ^{imiss_adr[6:0], dmiss_adr[5:0],
                           iline_full[IBEATS*BUS_WID-1:L1I_LINE_SIZE]};

endmodule

// File: tb/tb_rfblackwidow_fill_arb.sv
module tb_rfblackwidow_fill_arb;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         imiss_req, dmiss_req;
    logic [39:0]  imiss_adr, dmiss_adr;
    logic         imiss_ack, dmiss_ack, fill_err;
    logic [671:0] iline_o;
    logic [511:0] dline_o;
    logic         cyc_o, stb_o;
    logic [39:0]  adr_o;
    logic         ack_i, err_i;
    logic [127:0] dat_i;

    int checks = 0;
    int failures = 0;

    // reference model state: 1 = I-cache was granted last
    bit tb_last_i = 1'b0;

    // observations from the most recent bus service
    logic [39:0]  obs_adr[$];
    logic [127:0] obs_dat[$];
    bit           obs_iack, obs_dack, obs_err, obs_stb_at_ack, obs_timeout;
    bit           obs_rst_cyc, obs_rst_ack;
    int           obs_cyc, obs_first, obs_hold_bad;
    logic [671:0] obs_iline;
    logic [511:0] obs_dline;

    rfblackwidow_fill_arb dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .imiss_req (imiss_req),
        .imiss_adr (imiss_adr),
        .imiss_ack (imiss_ack),
        .iline_o   (iline_o),
        .dmiss_req (dmiss_req),
        .dmiss_adr (dmiss_adr),
        .dmiss_ack (dmiss_ack),
        .dline_o   (dline_o),
        .fill_err  (fill_err),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .adr_o     (adr_o),
        .ack_i     (ack_i),
        .err_i     (err_i),
        .dat_i     (dat_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [39:0] rand40();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[39:0];
    endfunction

    // Round-robin rule: single requester wins; on a tie the one not granted last.
    function automatic bit pick_i(input bit ri, input bit rd);
        return ri && (!rd || !tb_last_i);
    endfunction

    // Memory slave: acks every wait_n-th strobe cycle, optionally errors on
    // beat err_beat or raises reset on beat rst_beat. Records what it saw.
    task automatic serve(input int wait_n, input int err_beat, input int rst_beat);
        int k, nb;
        bit prev_ack, have;
        logic [39:0] last_adr;
        obs_adr.delete();
        obs_dat.delete();
        obs_iack = 0; obs_dack = 0; obs_err = 0; obs_stb_at_ack = 0;
        obs_timeout = 1; obs_cyc = 0; obs_first = 0; obs_hold_bad = 0;
        obs_rst_cyc = 0; obs_rst_ack = 0;
        k = 0; nb = 0; prev_ack = 0; have = 0; last_adr = '0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk_i);
            if (imiss_ack || dmiss_ack) begin
                obs_iack = imiss_ack; obs_dack = dmiss_ack; obs_err = fill_err;
                obs_stb_at_ack = stb_o; obs_iline = iline_o; obs_dline = dline_o;
                obs_cyc = c - obs_first + 1;
                ack_i = 0; err_i = 0;
                if (imiss_ack) imiss_req = 0;
                if (dmiss_ack) dmiss_req = 0;
                obs_timeout = 0;
                return;
            end
            ack_i = 0; err_i = 0;
            if (stb_o) begin
                if (obs_first == 0) obs_first = c;
                if (have && !prev_ack && adr_o !== last_adr) obs_hold_bad++;
                last_adr = adr_o; have = 1; prev_ack = 0;
                if (k % wait_n == wait_n - 1) begin
                    obs_adr.push_back(adr_o);
                    dat_i = rand128();
                    ack_i = 1;
                    prev_ack = 1;
                    if (nb == rst_beat) begin
                        rst_i = 1;
                        @(negedge clk_i);
                        obs_rst_cyc = cyc_o;
                        obs_rst_ack = imiss_ack | dmiss_ack;
                        rst_i = 0; ack_i = 0; obs_timeout = 0;
                        return;
                    end
                    if (nb == err_beat) err_i = 1;
                    else obs_dat.push_back(dat_i);
                    nb++;
                end
                k++;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1; imiss_req = 0; dmiss_req = 0; ack_i = 0; err_i = 0;
        imiss_adr = '0; dmiss_adr = '0; dat_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 0;
        tb_last_i = 0;
        checks++; if ({cyc_o, stb_o} !== 2'b00) begin failures++; $display("FAIL reset_bus got=%b want=00", {cyc_o, stb_o}); end
        checks++; if (adr_o !== 40'd0) begin failures++; $display("FAIL reset_adr got=%h want=0", adr_o); end
        checks++; if ({imiss_ack, dmiss_ack, fill_err} !== 3'b000) begin failures++; $display("FAIL reset_acks got=%b want=000", {imiss_ack, dmiss_ack, fill_err}); end
        checks++; if (iline_o !== '0 || dline_o !== '0) begin failures++; $display("FAIL reset_lines got=%h/%h want=0", iline_o[31:0], dline_o[31:0]); end
        // strobe-less acks must not start anything
        ack_i = 1;
        repeat (3) @(negedge clk_i);
        ack_i = 0;
        checks++; if (cyc_o !== 1'b0) begin failures++; $display("FAIL idle_stray_ack cyc got=%b want=0", cyc_o); end
    endtask

    task automatic test_d_fill();
        logic [511:0] e;
        dmiss_adr = 40'h12345; dmiss_req = 1;
        serve(1, -1, -1);
        tb_last_i = 0;
        checks++; if (obs_timeout || !obs_dack || obs_iack) begin failures++; $display("FAIL d_fill_ack got=i%b d%b to%b want=d only", obs_iack, obs_dack, obs_timeout); end
        checks++; if (obs_first !== 1) begin failures++; $display("FAIL d_fill_cyc_start got=%0d want=1", obs_first); end
        checks++; if (obs_cyc !== 5) begin failures++; $display("FAIL d_fill_ack_cycle got=%0d want=5", obs_cyc); end
        checks++; if (obs_err !== 1'b0 || obs_stb_at_ack !== 1'b0) begin failures++; $display("FAIL d_fill_err_stb got=%b%b want=00", obs_err, obs_stb_at_ack); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (obs_adr.size() <= j || obs_adr[j] !== 40'h12340 + 40'(16 * j)) begin
                failures++; $display("FAIL d_fill_adr%0d got=%h want=%h", j, (obs_adr.size() > j) ? obs_adr[j] : 40'hx, 40'h12340 + 40'(16 * j));
            end
        end
        e = '0;
        for (int j = 0; j < obs_dat.size(); j++) e[j*128 +: 128] = obs_dat[j];
        checks++; if (obs_dat.size() != 4 || obs_dline !== e) begin failures++; $display("FAIL d_fill_line got=%h want=%h", obs_dline[127:0], e[127:0]); end
    endtask

    task automatic test_tie();
        bit wi;
        logic [767:0] e;
        logic [39:0] ai, ad;
        for (int round = 0; round < 3; round++) begin
            // round 2 is preceded by a lone I fill so that D must win the tie
            if (round == 2) begin
                imiss_adr = rand40(); imiss_req = 1;
                serve(1, -1, -1);
                tb_last_i = 1;
                checks++; if (!obs_iack) begin failures++; $display("FAIL tie_pre_i got=%b want=1", obs_iack); end
                @(negedge clk_i);
            end
            ai = rand40(); ad = rand40();
            imiss_adr = ai; dmiss_adr = ad; imiss_req = 1; dmiss_req = 1;
            wi = pick_i(1, 1);
            for (int s = 0; s < 2; s++) begin
                bit ci;
                logic [39:0] b;
                ci = (s == 0) ? wi : !wi;
                b  = ci ? (ai & ~40'h7F) : (ad & ~40'h3F);
                serve(1, -1, -1);
                tb_last_i = ci;
                checks++; if (obs_iack !== ci || obs_dack !== !ci) begin failures++; $display("FAIL tie_r%0d_s%0d_side got=i%b d%b want_i=%b", round, s, obs_iack, obs_dack, ci); end
                checks++; if (obs_adr.size() == 0 || obs_adr[0] !== b) begin failures++; $display("FAIL tie_r%0d_s%0d_base got=%h want=%h", round, s, (obs_adr.size() > 0) ? obs_adr[0] : 40'hx, b); end
                e = '0;
                for (int j = 0; j < obs_dat.size(); j++) e[j*128 +: 128] = obs_dat[j];
                if (ci) begin
                    checks++; if (obs_dat.size() != 6 || obs_iline !== e[671:0]) begin failures++; $display("FAIL tie_r%0d_iline got=%h want=%h", round, obs_iline[127:0], e[127:0]); end
                end else begin
                    checks++; if (obs_dat.size() != 4 || obs_dline !== e[511:0]) begin failures++; $display("FAIL tie_r%0d_dline got=%h want=%h", round, obs_dline[127:0], e[127:0]); end
                end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_wait_states();
        logic [511:0] e;
        dmiss_adr = rand40(); dmiss_req = 1;
        serve(3, -1, -1);
        tb_last_i = 0;
        checks++; if (obs_hold_bad !== 0) begin failures++; $display("FAIL wait_hold got=%0d want=0", obs_hold_bad); end
        checks++; if (obs_cyc !== 4 * 3 + 1) begin failures++; $display("FAIL wait_ack_cycle got=%0d want=%0d", obs_cyc, 13); end
        e = '0;
        for (int j = 0; j < obs_dat.size(); j++) e[j*128 +: 128] = obs_dat[j];
        checks++; if (!obs_dack || obs_dline !== e) begin failures++; $display("FAIL wait_line got=%h want=%h", obs_dline[127:0], e[127:0]); end
        @(negedge clk_i);
    endtask

    task automatic test_error();
        logic [767:0] e;
        dmiss_adr = rand40(); dmiss_req = 1;
        serve(1, 2, -1);
        tb_last_i = 0;
        checks++; if (!obs_dack || obs_err !== 1'b1) begin failures++; $display("FAIL err_ack got=d%b err%b want=11", obs_dack, obs_err); end
        checks++; if (obs_cyc !== 4 || obs_stb_at_ack !== 1'b0) begin failures++; $display("FAIL err_timing got=cyc%0d stb%b want=cyc4 stb0", obs_cyc, obs_stb_at_ack); end
        @(negedge clk_i);
        imiss_adr = rand40(); imiss_req = 1;
        serve(1, -1, -1);
        tb_last_i = 1;
        e = '0;
        for (int j = 0; j < obs_dat.size(); j++) e[j*128 +: 128] = obs_dat[j];
        checks++; if (!obs_iack || obs_err !== 1'b0) begin failures++; $display("FAIL err_next_i got=i%b err%b want=10", obs_iack, obs_err); end
        checks++; if (obs_cyc !== 7 || obs_iline !== e[671:0]) begin failures++; $display("FAIL err_next_line got=cyc%0d %h want=cyc7 %h", obs_cyc, obs_iline[127:0], e[127:0]); end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_fill();
        logic [767:0] e;
        logic [39:0] a;
        a = rand40();
        imiss_adr = a; imiss_req = 1;
        serve(1, -1, 3);
        tb_last_i = 0;
        checks++; if (obs_rst_cyc !== 1'b0 || obs_rst_ack !== 1'b0) begin failures++; $display("FAIL rst_mid got=cyc%b ack%b want=00", obs_rst_cyc, obs_rst_ack); end
        serve(1, -1, -1);
        tb_last_i = 1;
        e = '0;
        for (int j = 0; j < obs_dat.size(); j++) e[j*128 +: 128] = obs_dat[j];
        checks++; if (obs_adr.size() != 6 || obs_adr[0] !== (a & ~40'h7F)) begin failures++; $display("FAIL rst_restart_base got=%h want=%h", (obs_adr.size() > 0) ? obs_adr[0] : 40'hx, a & ~40'h7F); end
        checks++; if (!obs_iack || obs_iline !== e[671:0]) begin failures++; $display("FAIL rst_restart_line got=%h want=%h", obs_iline[127:0], e[127:0]); end
        @(negedge clk_i);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int pat;
            bit ri, rd, wi;
            logic [39:0] ai, ad;
            pat = $urandom_range(1, 3);
            ri = pat[0]; rd = pat[1];
            ai = rand40(); ad = rand40();
            imiss_adr = ai; dmiss_adr = ad; imiss_req = ri; dmiss_req = rd;
            wi = pick_i(ri, rd);
            for (int s = 0; s < ((ri && rd) ? 2 : 1); s++) begin
                bit ci;
                int w, nb;
                logic [39:0] b;
                logic [767:0] e;
                bit adr_ok;
                ci = (s == 0) ? wi : !wi;
                nb = ci ? 6 : 4;
                b  = ci ? (ai & ~40'h7F) : (ad & ~40'h3F);
                w  = $urandom_range(1, 3);
                serve(w, -1, -1);
                tb_last_i = ci;
                e = '0;
                for (int j = 0; j < obs_dat.size(); j++) e[j*128 +: 128] = obs_dat[j];
                adr_ok = (obs_adr.size() == nb);
                for (int j = 0; j < obs_adr.size(); j++) if (obs_adr[j] !== b + 40'(16 * j)) adr_ok = 0;
                checks++; if (obs_timeout || obs_iack !== ci || obs_dack !== !ci || obs_err) begin failures++; $display("FAIL rnd%0d_s%0d_ack got=i%b d%b e%b want_i=%b", it, s, obs_iack, obs_dack, obs_err, ci); end
                checks++; if (obs_cyc !== nb * w + 1 || obs_hold_bad != 0) begin failures++; $display("FAIL rnd%0d_s%0d_timing got=%0d hold%0d want=%0d", it, s, obs_cyc, obs_hold_bad, nb * w + 1); end
                checks++; if (!adr_ok) begin failures++; $display("FAIL rnd%0d_s%0d_adr got=%h want_base=%h", it, s, (obs_adr.size() > 0) ? obs_adr[0] : 40'hx, b); end
                checks++; if (ci ? (obs_iline !== e[671:0]) : (obs_dline !== e[511:0])) begin failures++; $display("FAIL rnd%0d_s%0d_line want_i=%b", it, s, ci); end
            end
            repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end
    endtask

    task automatic test_timeout();
        bit seen_ack, seen_err;
        seen_ack = 0; seen_err = 0;
        dmiss_adr = rand40(); dmiss_req = 1;
        ack_i = 0; err_i = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_i);
            if (dmiss_ack) begin seen_ack = 1; seen_err = fill_err; dmiss_req = 0; end
        end
`ifdef RFBW_FILL_TIMEOUT_EN
        checks++; if (!seen_ack || !seen_err) begin failures++; $display("FAIL timeout_abort got=ack%b err%b want=11", seen_ack, seen_err); end
`else
        checks++; if (seen_ack || cyc_o !== 1'b1) begin failures++; $display("FAIL no_timeout_hold got=ack%b cyc%b want=ack0 cyc1", seen_ack, cyc_o); end
`endif
        dmiss_req = 0;
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        tb_last_i = 0;
        checks++; if (cyc_o !== 1'b0) begin failures++; $display("FAIL timeout_reset cyc got=%b want=0", cyc_o); end
    endtask

    initial begin
        test_reset();
        test_d_fill();
        @(negedge clk_i);
        test_tie();
        test_wait_states();
        test_error();
        test_reset_mid_fill();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
